// File: rtl/ex_stage.sv
// ex_stage: execute stage of a 5-stage MIPS pipeline.
//
// Registers the ID->EX bus, evaluates the ALU, owns HI/LO together with a
// single-cycle multiplier and a 32-step restoring divider, and drives the
// data SRAM request, the EX->MEM bus and the forwarding outputs.
//
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   stall[5:0]        pipeline stall vector (1 = stop)
//   id_to_ex_bus      148-bit decoded instruction from ID
//   ex_to_mem_bus     76-bit {pc, ram_en, ram_wen, sel_rf_res, rf_we, rf_waddr, ex_result}
//   data_sram_*       data SRAM enable / byte write enable / address / write data
//   ex_wreg/waddr/wdata  forwarding copies of rf_we / rf_waddr / ex_result
//   stallreq_for_ex   high while a divide is issuing or iterating
//   div_state         divider FSM state (0 IDLE, 1 BUSY, 2 DONE), for observation
//
// Stall semantics: stall[2] stops this stage's input register, stall[3]
// means MEM is not accepting. When EX is stopped but MEM is accepting, the
// input register is cleared so a bubble moves on to MEM. HI/LO updates only
// happen while MEM is accepting, so a held instruction never commits twice.
module ex_stage #(
  parameter int ID_TO_EX_WD  = 148,
  parameter int EX_TO_MEM_WD = 76,
  parameter int DIV_CYCLES   = 32
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [5:0]              stall,
  input  logic [ID_TO_EX_WD-1:0]  id_to_ex_bus,
  output logic [EX_TO_MEM_WD-1:0] ex_to_mem_bus,
  output logic                    data_sram_en,
  output logic [3:0]              data_sram_wen,
  output logic [31:0]             data_sram_addr,
  output logic [31:0]             data_sram_wdata,
  output logic                    ex_wreg,
  output logic [4:0]              ex_waddr,
  output logic [31:0]             ex_wdata,
  output logic                    stallreq_for_ex,
  output logic [1:0]              div_state
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } div_state_t;

  localparam logic [3:0] MD_NONE  = 4'd0;
  localparam logic [3:0] MD_MULT  = 4'd1;
  localparam logic [3:0] MD_MULTU = 4'd2;
  localparam logic [3:0] MD_DIV   = 4'd3;
  localparam logic [3:0] MD_DIVU  = 4'd4;
  localparam logic [3:0] MD_MFHI  = 4'd5;
  localparam logic [3:0] MD_MFLO  = 4'd6;
  localparam logic [3:0] MD_MTHI  = 4'd7;
  localparam logic [3:0] MD_MTLO  = 4'd8;

  localparam logic [4:0] LAST_STEP = 5'(DIV_CYCLES - 1);

  // Input register
  logic [ID_TO_EX_WD-1:0] ex_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      ex_reg <= '0;
    end else if (stall[2] && !stall[3]) begin
      ex_reg <= '0;
    end else if (!stall[2]) begin
      ex_reg <= id_to_ex_bus;
    end
  end

  logic [31:0] pc;
  logic [3:0]  alu_op;
  logic [3:0]  md_op;
  logic        data_ram_en;
  logic [3:0]  data_ram_wen;
  logic        sel_rf_res;
  logic        rf_we;
  logic [4:0]  rf_waddr;
  logic [31:0] src1;
  logic [31:0] src2;
  logic [31:0] store_data;

  assign pc           = ex_reg[147:116];
  assign alu_op       = ex_reg[115:112];
  assign md_op        = ex_reg[111:108];
  assign data_ram_en  = ex_reg[107];
  assign data_ram_wen = ex_reg[106:103];
  assign sel_rf_res   = ex_reg[102];
  assign rf_we        = ex_reg[101];
  assign rf_waddr     = ex_reg[100:96];
  assign src1         = ex_reg[95:64];
  assign src2         = ex_reg[63:32];
  assign store_data   = ex_reg[31:0];

  // ALU
  logic [31:0] alu_res;

  always_comb begin
    alu_res = '0;
    case (alu_op)
      4'd0:    alu_res = src1 + src2;
      4'd1:    alu_res = src1 - src2;
      4'd2:    alu_res = {31'd0, $signed(src1) < $signed(src2)};
      4'd3:    alu_res = {31'd0, src1 < src2};
      4'd4:    alu_res = src1 & src2;
      4'd5:    alu_res = src1 | src2;
      4'd6:    alu_res = src1 ^ src2;
      4'd7:    alu_res = ~(src1 | src2);
      4'd8:    alu_res = src2 << src1[4:0];
      4'd9:    alu_res = src2 >> src1[4:0];
      4'd10:   alu_res = $signed(src2) >>> src1[4:0];
      4'd11:   alu_res = {src2[15:0], 16'd0};
      default: alu_res = '0;
    endcase
  end

  // HI/LO, multiplier, divider
  logic [31:0] hi;
  logic [31:0] lo;
  div_state_t  state;
  logic [4:0]  count;
  logic [31:0] div_q;       // dividend shifting out, quotient shifting in
  logic [31:0] div_r;       // partial remainder
  logic [31:0] div_d;       // divisor magnitude
  logic [31:0] div_src1;    // original dividend, returned in HI on divide by zero
  logic        div_zero;
  logic        neg_q;
  logic        neg_r;

  logic [63:0] prod_s;
  logic [63:0] prod_u;
  assign prod_s = {{32{src1[31]}}, src1} * {{32{src2[31]}}, src2};
  assign prod_u = {32'd0, src1} * {32'd0, src2};

  logic        is_div;
  logic        div_signed;
  logic        s1_neg;
  logic        s2_neg;
  logic [31:0] abs1;
  logic [31:0] abs2;
  assign is_div     = (md_op == MD_DIV) || (md_op == MD_DIVU);
  assign div_signed = (md_op == MD_DIV);
  assign s1_neg     = div_signed && src1[31];
  assign s2_neg     = div_signed && src2[31];
  assign abs1       = s1_neg ? (~src1 + 32'd1) : src1;
  assign abs2       = s2_neg ? (~src2 + 32'd1) : src2;

  // One restoring step: shift the next dividend bit into the remainder and
  // subtract the divisor if it fits. The remainder stays below the divisor,
  // so the shifted value fits in 33 bits and the difference in 32.
  logic [32:0] trial;
  logic [32:0] trial_diff;
  logic        fits;
  assign trial      = {div_r, div_q[31]};
  assign trial_diff = trial - {1'b0, div_d};
  assign fits       = (trial >= {1'b0, div_d});

  always_ff @(posedge clk) begin
    if (rst) begin
      hi       <= '0;
      lo       <= '0;
      state    <= IDLE;
      count    <= '0;
      div_q    <= '0;
      div_r    <= '0;
      div_d    <= '0;
      div_src1 <= '0;
      div_zero <= 1'b0;
      neg_q    <= 1'b0;
      neg_r    <= 1'b0;
    end else begin
      if (!stall[3] && md_op != MD_NONE) begin
        case (md_op)
          MD_MULT:  {hi, lo} <= prod_s;
          MD_MULTU: {hi, lo} <= prod_u;
          MD_MTHI:  hi <= src1;
          MD_MTLO:  lo <= src1;
          default:  ;
        endcase
      end
      case (state)
        IDLE: begin
          if (is_div) begin
            div_q    <= abs1;
            div_r    <= '0;
            div_d    <= abs2;
            div_src1 <= src1;
            div_zero <= (src2 == 32'd0);
            neg_q    <= s1_neg ^ s2_neg;
            neg_r    <= s1_neg;
            count    <= '0;
            state    <= BUSY;
          end
        end
        BUSY: begin
          div_r <= fits ? trial_diff[31:0] : trial[31:0];
          div_q <= {div_q[30:0], fits};
          count <= count + 5'd1;
          if (count == LAST_STEP) state <= DONE;
        end
        DONE: begin
          // Lands on the same edge the next instruction enters EX, so an
          // MFHI/MFLO right behind the divide already sees the result.
          if (!stall[3]) begin
            if (div_zero) begin
              hi <= div_src1;
              lo <= 32'hFFFF_FFFF;
            end else begin
              hi <= neg_r ? (~div_r + 32'd1) : div_r;
              lo <= neg_q ? (~div_q + 32'd1) : div_q;
            end
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign stallreq_for_ex = ((state == IDLE) && is_div) || (state == BUSY);
  assign div_state       = state;

  // Outputs
  logic [31:0] ex_result;
  always_comb begin
    ex_result = alu_res;
    if (md_op == MD_MFHI)      ex_result = hi;
    else if (md_op == MD_MFLO) ex_result = lo;
  end

  assign ex_to_mem_bus   = {pc, data_ram_en, data_ram_wen, sel_rf_res, rf_we,
                            rf_waddr, ex_result};
  assign data_sram_en    = data_ram_en;
  assign data_sram_wen   = (data_ram_wen == 4'b1111) ? 4'b1111 : 4'b0000;
  assign data_sram_addr  = ex_result;
  assign data_sram_wdata = store_data;
  assign ex_wreg         = rf_we;
  assign ex_waddr        = rf_waddr;
  assign ex_wdata        = ex_result;

endmodule

// File: tb/tb_ex_stage.sv
// Testbench for ex_stage. A small controller model turns stallreq_for_ex
// into the stall vector; expected ex_result values are queued as each
// instruction is driven and popped when it reaches the EX register.
module tb_ex_stage;

  logic         clk;
  logic         rst;
  logic [5:0]   stall;
  logic [147:0] id_to_ex_bus;
  logic [75:0]  ex_to_mem_bus;
  logic         data_sram_en;
  logic [3:0]   data_sram_wen;
  logic [31:0]  data_sram_addr;
  logic [31:0]  data_sram_wdata;
  logic         ex_wreg;
  logic [4:0]   ex_waddr;
  logic [31:0]  ex_wdata;
  logic         stallreq_for_ex;
  logic [1:0]   div_state;

  logic         hold_mem;
  logic [31:0]  exp_q[$];
  int           tests_run;
  int           tests_failed;

  ex_stage dut (
    .clk             (clk),
    .rst             (rst),
    .stall           (stall),
    .id_to_ex_bus    (id_to_ex_bus),
    .ex_to_mem_bus   (ex_to_mem_bus),
    .data_sram_en    (data_sram_en),
    .data_sram_wen   (data_sram_wen),
    .data_sram_addr  (data_sram_addr),
    .data_sram_wdata (data_sram_wdata),
    .ex_wreg         (ex_wreg),
    .ex_waddr        (ex_waddr),
    .ex_wdata        (ex_wdata),
    .stallreq_for_ex (stallreq_for_ex),
    .div_state       (div_state)
  );

  // Clock and controller
  initial clk = 1'b0;
  always #5 clk = ~clk;

  always_comb begin
    if (stallreq_for_ex) stall = 6'b000111;
    else if (hold_mem)   stall = 6'b001111;
    else                 stall = 6'b000000;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  // Driver helpers
  function automatic [147:0] mk(input [3:0] alu, input [3:0] md,
                                input ren, input [3:0] wen, input we,
                                input [4:0] waddr, input [31:0] s1,
                                input [31:0] s2, input [31:0] sd);
    mk = {32'h0040_0000, alu, md, ren, wen, 1'b0, we, waddr, s1, s2, sd};
  endfunction

  task automatic issue(input [147:0] b, input [31:0] exp);
    id_to_ex_bus = b;
    exp_q.push_back(exp);
    @(posedge clk);
    #1;
  endtask

  task automatic wait_div(output int cnt);
    cnt = 0;
    while (stallreq_for_ex && cnt < 100) begin
      cnt++;
      @(posedge clk);
      #1;
    end
  endtask

  function automatic [31:0] ref_alu(input [3:0] op, input [31:0] a, input [31:0] b);
    case (op)
      4'd0:    ref_alu = a + b;
      4'd1:    ref_alu = a + ~b + 32'd1;
      4'd4:    ref_alu = a & b;
      4'd5:    ref_alu = a | b;
      4'd6:    ref_alu = (a | b) & ~(a & b);
      4'd7:    ref_alu = ~a & ~b;
      4'd8:    ref_alu = b * (32'd1 << a[4:0]);
      default: ref_alu = b / (32'd1 << a[4:0]);
    endcase
  endfunction

  // Tests
  task automatic test_reset();
    id_to_ex_bus = mk(4'd0, 4'd3, 1'b1, 4'hF, 1'b1, 5'd7, 32'h11, 32'h22, 32'h33);
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    tests_run++;
    if (ex_to_mem_bus !== 76'd0) begin
      tests_failed++;
      $display("FAIL reset_bus: got %h exp 0", ex_to_mem_bus);
    end
    tests_run++;
    if (data_sram_en !== 1'b0 || stallreq_for_ex !== 1'b0 || div_state !== 2'd0) begin
      tests_failed++;
      $display("FAIL reset_ctl: en=%b stallreq=%b state=%0d exp 0/0/0",
               data_sram_en, stallreq_for_ex, div_state);
    end
    rst = 1'b0;
    id_to_ex_bus = '0;
    @(posedge clk);
    #1;
  endtask

  task automatic test_alu();
    logic [31:0] e;
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [3:0]  ops[8];
    ops = '{4'd0, 4'd1, 4'd4, 4'd5, 4'd6, 4'd7, 4'd8, 4'd9};

    issue(mk(4'd1, 4'd0, 1'b0, 4'h0, 1'b1, 5'd1, 32'd5, 32'd7, 32'd0), 32'hFFFF_FFFE);
    e = exp_q.pop_front();
    tests_run++;
    if (ex_wdata !== e) begin tests_failed++; $display("FAIL alu_sub: got %h exp %h", ex_wdata, e); end

    issue(mk(4'd10, 4'd0, 1'b0, 4'h0, 1'b1, 5'd1, 32'd4, 32'h8000_0000, 32'd0), 32'hF800_0000);
    e = exp_q.pop_front();
    tests_run++;
    if (ex_wdata !== e) begin tests_failed++; $display("FAIL alu_sra: got %h exp %h", ex_wdata, e); end

    issue(mk(4'd2, 4'd0, 1'b0, 4'h0, 1'b1, 5'd1, 32'hFFFF_FFFF, 32'd1, 32'd0), 32'd1);
    e = exp_q.pop_front();
    tests_run++;
    if (ex_wdata !== e) begin tests_failed++; $display("FAIL alu_slt: got %h exp %h", ex_wdata, e); end

    issue(mk(4'd3, 4'd0, 1'b0, 4'h0, 1'b1, 5'd1, 32'hFFFF_FFFF, 32'd1, 32'd0), 32'd0);
    e = exp_q.pop_front();
    tests_run++;
    if (ex_wdata !== e) begin tests_failed++; $display("FAIL alu_sltu: got %h exp %h", ex_wdata, e); end

    issue(mk(4'd11, 4'd0, 1'b0, 4'h0, 1'b1, 5'd1, 32'd0, 32'h0000_1234, 32'd0), 32'h1234_0000);
    e = exp_q.pop_front();
    tests_run++;
    if (ex_wdata !== e) begin tests_failed++; $display("FAIL alu_lui: got %h exp %h", ex_wdata, e); end

    issue(mk(4'd13, 4'd0, 1'b0, 4'h0, 1'b1, 5'd1, 32'd9, 32'd9, 32'd0), 32'd0);
    e = exp_q.pop_front();
    tests_run++;
    if (ex_wdata !== e) begin tests_failed++; $display("FAIL alu_undef: got %h exp %h", ex_wdata, e); end

    for (int i = 0; i < 12; i++) begin
      op = ops[$urandom_range(0, 7)];
      a  = $urandom();
      b  = $urandom();
      issue(mk(op, 4'd0, 1'b0, 4'h0, 1'b1, 5'd2, a, b, 32'd0), ref_alu(op, a, b));
      e = exp_q.pop_front();
      tests_run++;
      if (ex_wdata !== e) begin
        tests_failed++;
        $display("FAIL alu_rand op=%0d a=%h b=%h: got %h exp %h", op, a, b, ex_wdata, e);
      end
    end
  endtask

  task automatic test_store_load();
    logic [31:0] e;
    issue(mk(4'd0, 4'd0, 1'b1, 4'b1111, 1'b0, 5'd0, 32'h100, 32'h4, 32'hDEAD_BEEF), 32'h104);
    e = exp_q.pop_front();
    tests_run++;
    if (data_sram_addr !== e || data_sram_en !== 1'b1 || data_sram_wen !== 4'hF ||
        data_sram_wdata !== 32'hDEAD_BEEF) begin
      tests_failed++;
      $display("FAIL store: en=%b wen=%h addr=%h wdata=%h exp 1/f/%h/deadbeef",
               data_sram_en, data_sram_wen, data_sram_addr, data_sram_wdata, e);
    end

    issue(mk(4'd0, 4'd0, 1'b1, 4'b0001, 1'b1, 5'd5, 32'h200, 32'h8, 32'd0), 32'h208);
    e = exp_q.pop_front();
    tests_run++;
    if (data_sram_addr !== e || data_sram_wen !== 4'h0 || ex_to_mem_bus[42:39] !== 4'b0001 ||
        ex_wreg !== 1'b1 || ex_waddr !== 5'd5) begin
      tests_failed++;
      $display("FAIL load: addr=%h sram_wen=%h bus_wen=%b wreg=%b waddr=%0d exp %h/0/0001/1/5",
               data_sram_addr, data_sram_wen, ex_to_mem_bus[42:39], ex_wreg, ex_waddr, e);
    end
  endtask

  task automatic test_mult();
    logic [31:0] e;
    issue(mk(4'd0, 4'd1, 1'b0, 4'h0, 1'b0, 5'd0, 32'hFFFF_FFFD, 32'd7, 32'd0), 32'd4);
    e = exp_q.pop_front();
    tests_run++;
    if (ex_wdata !== e) begin tests_failed++; $display("FAIL mult_alu: got %h exp %h", ex_wdata, e); end

    issue(mk(4'd0, 4'd5, 1'b0, 4'h0, 1'b1, 5'd3, 32'd0, 32'd0, 32'd0), 32'hFFFF_FFFF);
    e = exp_q.pop_front();
    tests_run++;
    if (ex_wdata !== e) begin tests_failed++; $display("FAIL mult_hi: got %h exp %h", ex_wdata, e); end

    issue(mk(4'd0, 4'd6, 1'b0, 4'h0, 1'b1, 5'd3, 32'd0, 32'd0, 32'd0), 32'hFFFF_FFEB);
    e = exp_q.pop_front();
    tests_run++;
    if (ex_wdata !== e) begin tests_failed++; $display("FAIL mult_lo: got %h exp %h", ex_wdata, e); end

    issue(mk(4'd4, 4'd2, 1'b0, 4'h0, 1'b0, 5'd0, 32'hFFFF_FFFF, 32'd2, 32'd0), 32'd2);
    void'(exp_q.pop_front());
    issue(mk(4'd0, 4'd5, 1'b0, 4'h0, 1'b1, 5'd3, 32'd0, 32'd0, 32'd0), 32'd1);
    e = exp_q.pop_front();
    tests_run++;
    if (ex_wdata !== e) begin tests_failed++; $display("FAIL multu_hi: got %h exp %h", ex_wdata, e); end

    issue(mk(4'd0, 4'd6, 1'b0, 4'h0, 1'b1, 5'd3, 32'd0, 32'd0, 32'd0), 32'hFFFF_FFFE);
    e = exp_q.pop_front();
    tests_run++;
    if (ex_wdata !== e) begin tests_failed++; $display("FAIL multu_lo: got %h exp %h", ex_wdata, e); end

    issue(mk(4'd0, 4'd7, 1'b0, 4'h0, 1'b0, 5'd0, 32'h0000_ABCD, 32'd0, 32'd0), 32'h0000_ABCD);
    void'(exp_q.pop_front());
    issue(mk(4'd0, 4'd5, 1'b0, 4'h0, 1'b1, 5'd3, 32'd0, 32'd0, 32'd0), 32'h0000_ABCD);
    e = exp_q.pop_front();
    tests_run++;
    if (ex_wdata !== e) begin tests_failed++; $display("FAIL mthi: got %h exp %h", ex_wdata, e); end
  endtask

  task automatic test_div();
    logic [31:0] e;
    int          cnt;
    // The DIV instruction itself reports the ALU sum of its operands.
    issue(mk(4'd0, 4'd3, 1'b0, 4'h0, 1'b0, 5'd0, 32'hFFFF_FFF9, 32'd2, 32'd0), 32'hFFFF_FFFB);
    e = exp_q.pop_front();
    tests_run++;
    if (ex_wdata !== e) begin tests_failed++; $display("FAIL div_issue: got %h exp %h", ex_wdata, e); end
    id_to_ex_bus = mk(4'd0, 4'd6, 1'b0, 4'h0, 1'b1, 5'd4, 32'd0, 32'd0, 32'd0);
    @(posedge clk);
    #1;
    tests_run++;
    if (ex_to_mem_bus !== 76'd0 || div_state !== 2'd1) begin
      tests_failed++;
      $display("FAIL div_bubble: bus=%h state=%0d exp 0/1", ex_to_mem_bus, div_state);
    end
    wait_div(cnt);
    tests_run++;
    if (cnt + 1 != 33) begin tests_failed++; $display("FAIL div_stall_len: got %0d exp 33", cnt + 1); end
    issue(mk(4'd0, 4'd6, 1'b0, 4'h0, 1'b1, 5'd4, 32'd0, 32'd0, 32'd0), 32'hFFFF_FFFD);
    e = exp_q.pop_front();
    tests_run++;
    if (ex_wdata !== e || stallreq_for_ex !== 1'b0) begin
      tests_failed++;
      $display("FAIL div_lo: got %h stallreq=%b exp %h/0", ex_wdata, stallreq_for_ex, e);
    end
    issue(mk(4'd0, 4'd5, 1'b0, 4'h0, 1'b1, 5'd4, 32'd0, 32'd0, 32'd0), 32'hFFFF_FFFF);
    e = exp_q.pop_front();
    tests_run++;
    if (ex_wdata !== e) begin tests_failed++; $display("FAIL div_hi: got %h exp %h", ex_wdata, e); end
  endtask

  task automatic test_div_stall_done();
    logic [31:0] e;
    int          cnt;
    issue(mk(4'd0, 4'd3, 1'b0, 4'h0, 1'b0, 5'd0, 32'd7, 32'hFFFF_FFFE, 32'd0), 32'd5);
    void'(exp_q.pop_front());
    id_to_ex_bus = mk(4'd0, 4'd6, 1'b0, 4'h0, 1'b1, 5'd4, 32'd0, 32'd0, 32'd0);
    wait_div(cnt);
    hold_mem = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    tests_run++;
    if (div_state !== 2'd2 || stallreq_for_ex !== 1'b0) begin
      tests_failed++;
      $display("FAIL div_done_hold: state=%0d stallreq=%b exp 2/0", div_state, stallreq_for_ex);
    end
    hold_mem = 1'b0;
    issue(mk(4'd0, 4'd6, 1'b0, 4'h0, 1'b1, 5'd4, 32'd0, 32'd0, 32'd0), 32'hFFFF_FFFD);
    e = exp_q.pop_front();
    tests_run++;
    if (ex_wdata !== e) begin tests_failed++; $display("FAIL div_neg_divisor_lo: got %h exp %h", ex_wdata, e); end
    issue(mk(4'd0, 4'd5, 1'b0, 4'h0, 1'b1, 5'd4, 32'd0, 32'd0, 32'd0), 32'd1);
    e = exp_q.pop_front();
    tests_run++;
    if (ex_wdata !== e) begin tests_failed++; $display("FAIL div_neg_divisor_hi: got %h exp %h", ex_wdata, e); end
  endtask

  task automatic test_div_zero();
    logic [31:0] e;
    int          cnt;
    issue(mk(4'd0, 4'd4, 1'b0, 4'h0, 1'b0, 5'd0, 32'd100, 32'd0, 32'd0), 32'd100);
    void'(exp_q.pop_front());
    id_to_ex_bus = mk(4'd0, 4'd6, 1'b0, 4'h0, 1'b1, 5'd4, 32'd0, 32'd0, 32'd0);
    wait_div(cnt);
    tests_run++;
    if (cnt != 33) begin tests_failed++; $display("FAIL div0_stall_len: got %0d exp 33", cnt); end
    issue(mk(4'd0, 4'd6, 1'b0, 4'h0, 1'b1, 5'd4, 32'd0, 32'd0, 32'd0), 32'hFFFF_FFFF);
    e = exp_q.pop_front();
    tests_run++;
    if (ex_wdata !== e) begin tests_failed++; $display("FAIL div0_lo: got %h exp %h", ex_wdata, e); end
    issue(mk(4'd0, 4'd5, 1'b0, 4'h0, 1'b1, 5'd4, 32'd0, 32'd0, 32'd0), 32'd100);
    e = exp_q.pop_front();
    tests_run++;
    if (ex_wdata !== e) begin tests_failed++; $display("FAIL div0_hi: got %h exp %h", ex_wdata, e); end
  endtask

  task automatic test_reset_abort();
    logic [31:0] e;
    issue(mk(4'd0, 4'd4, 1'b0, 4'h0, 1'b0, 5'd0, 32'd1000, 32'd3, 32'd0), 32'd1003);
    void'(exp_q.pop_front());
    id_to_ex_bus = '0;
    repeat (11) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    tests_run++;
    if (div_state !== 2'd0 || stallreq_for_ex !== 1'b0) begin
      tests_failed++;
      $display("FAIL abort_state: state=%0d stallreq=%b exp 0/0", div_state, stallreq_for_ex);
    end
    issue(mk(4'd0, 4'd5, 1'b0, 4'h0, 1'b1, 5'd4, 32'd0, 32'd0, 32'd0), 32'd0);
    e = exp_q.pop_front();
    tests_run++;
    if (ex_wdata !== e) begin tests_failed++; $display("FAIL abort_hi: got %h exp %h", ex_wdata, e); end
    issue(mk(4'd0, 4'd6, 1'b0, 4'h0, 1'b1, 5'd4, 32'd0, 32'd0, 32'd0), 32'd0);
    e = exp_q.pop_front();
    tests_run++;
    if (ex_wdata !== e) begin tests_failed++; $display("FAIL abort_lo: got %h exp %h", ex_wdata, e); end
  endtask

  // Sequence and report
  initial begin
    tests_run    = 0;
    tests_failed = 0;
    hold_mem     = 1'b0;
    rst          = 1'b1;
    id_to_ex_bus = '0;
    test_reset();
    test_alu();
    test_store_load();
    test_mult();
    test_div();
    test_div_stall_done();
    test_div_zero();
    test_reset_abort();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
